// File: rtl/ltssm_timer_arbiter_if.sv
// Bundle between the RX/TX LTSSM controllers and the shared millisecond timer.
// The master side drives the requests; the slave side is the arbiter.
interface ltssm_timer_arbiter_if;
   logic [1:0] startTimer;
   logic [1:0] enableTimer;
   logic [2:0] timeToWait0;
   logic [2:0] timeToWait1;
   logic [1:0] grant;
   logic [1:0] timeOut;
   logic       busy;
   logic [1:0] pending;

   modport master (
      output startTimer, enableTimer, timeToWait0, timeToWait1,
      input  grant, timeOut, busy, pending
   );

   modport slave (
      input  startTimer, enableTimer, timeToWait0, timeToWait1,
      output grant, timeOut, busy, pending
   );
endinterface

// File: rtl/ltssm_timer_arbiter.sv
// Shared ms timeout counter for the RX (0) and TX (1) LTSSMs with round-robin start arbitration.
// Define LTSSM_TIMER_FAST_SIM_EN to scale 1 ms down to SIM_CYCLES_PER_MS cycles.
module ltssm_timer_arbiter #(
   parameter int unsigned CYCLES_PER_MS     = 1000,
   parameter int unsigned SIM_CYCLES_PER_MS = 4,
   parameter int unsigned CNT_W             = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   ltssm_timer_arbiter_if.slave bus
);

`ifdef LTSSM_TIMER_FAST_SIM_EN
   localparam bit FAST_SIM = 1'b1;
`else
   localparam bit FAST_SIM = 1'b0;
`endif
   localparam int unsigned MS_MULT = FAST_SIM ? SIM_CYCLES_PER_MS : CYCLES_PER_MS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] count_q, count_nxt;
   logic [CNT_W-1:0] target_q, target_nxt;
   logic [1:0]       grant_q, grant_nxt;
   logic [1:0]       timeout_q, timeout_nxt;
   logic [1:0]       pending_q, pending_nxt;
   logic             busy_q, busy_nxt;
   logic             last_q, last_nxt;

   logic [1:0]       cand;
   logic             pick;
   logic             owner;
   logic             other;

   // Code to cycle count; reserved code 7 behaves like code 0.
   function automatic logic [CNT_W-1:0] decode_target(input logic [2:0] code);
      logic [CNT_W-1:0] ms;
      case (code)
         3'd1:    ms = CNT_W'(12);
         3'd2:    ms = CNT_W'(24);
         3'd3:    ms = CNT_W'(48);
         3'd4:    ms = CNT_W'(2);
         3'd5:    ms = CNT_W'(8);
         3'd6:    ms = CNT_W'(1);
         default: ms = CNT_W'(0);
      endcase
      return ms * CNT_W'(MS_MULT);
   endfunction

   assign owner = grant_q[1];
   assign other = ~grant_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         target_q  <= '0;
         grant_q   <= '0;
         timeout_q <= '0;
         pending_q <= '0;
         busy_q    <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         count_q   <= count_nxt;
         target_q  <= target_nxt;
         grant_q   <= grant_nxt;
         timeout_q <= timeout_nxt;
         pending_q <= pending_nxt;
         busy_q    <= busy_nxt;
         last_q    <= last_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_q;
      count_nxt   = count_q;
      target_nxt  = target_q;
      grant_nxt   = grant_q;
      timeout_nxt = timeout_q;
      pending_nxt = pending_q;
      last_nxt    = last_q;

      // On a tie the requester not served last wins.
      cand = bus.startTimer | pending_q;
      if (cand == 2'b11) pick = ~last_q;
      else               pick = cand[1];

      case (state_q)
         IDLE: begin
            if (cand != 2'b00) begin
               grant_nxt   = pick ? 2'b10 : 2'b01;
               pending_nxt = (pending_q | bus.startTimer) & ~(pick ? 2'b10 : 2'b01);
               last_nxt    = pick;
               count_nxt   = '0;
               target_nxt  = decode_target(pick ? bus.timeToWait1 : bus.timeToWait0);
               timeout_nxt = '0;
               state_nxt   = RUN;
            end
         end
         RUN, EXPIRED: begin
            if (bus.startTimer[other]) pending_nxt[other] = 1'b1;
            // Release beats restart, restart beats expiry.
            if (!bus.enableTimer[owner]) begin
               grant_nxt   = '0;
               timeout_nxt = '0;
               state_nxt   = IDLE;
            end else if (bus.startTimer[owner]) begin
               count_nxt   = '0;
               target_nxt  = decode_target(owner ? bus.timeToWait1 : bus.timeToWait0);
               timeout_nxt = '0;
               state_nxt   = RUN;
            end else if (state_q == RUN) begin
               if ((target_q == '0) || (count_q == target_q - CNT_W'(1))) begin
                  timeout_nxt = grant_q;
                  state_nxt   = EXPIRED;
               end else begin
                  count_nxt = count_q + CNT_W'(1);
               end
            end
         end
         default: begin
            grant_nxt   = '0;
            timeout_nxt = '0;
            state_nxt   = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   assign bus.grant   = grant_q;
   assign bus.timeOut = timeout_q;
   assign bus.busy    = busy_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_ltssm_timer_arbiter.sv
// Bench for ltssm_timer_arbiter: a deadline-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations (4 cycles per ms).
module tb_ltssm_timer_arbiter;
   localparam int unsigned MULT = 4;

   logic clk;
   logic reset;
   ltssm_timer_arbiter_if bus ();

   ltssm_timer_arbiter #(
      .CYCLES_PER_MS     (MULT),
      .SIM_CYCLES_PER_MS (MULT),
      .CNT_W             (20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   int ms_tab [8] = '{0, 12, 24, 48, 2, 8, 1, 0};

   // Model: an owner, an absolute expiry edge, a pending set and the last-served requester.
   int         edge_n   = 0;
   int         m_owner  = -1;
   int         m_deadline = 0;
   logic [1:0] m_pend   = 2'b00;
   int         m_last   = 1;
   bit         m_valid  = 1'b0;
   logic [1:0] e_grant, e_to, e_pend;
   logic       e_busy;

   function automatic int dur(input int r);
      int t;
      t = ms_tab[(r == 1) ? int'(bus.timeToWait1) : int'(bus.timeToWait0)] * int'(MULT);
      return (t < 1) ? 1 : t;
   endfunction

   task automatic model_step();
      logic [1:0] st, en, cand;
      int pick, other;
      st = bus.startTimer;
      en = bus.enableTimer;
      edge_n++;
      if (reset) begin
         m_owner = -1; m_pend = 2'b00; m_last = 1; m_valid = 1'b1;
      end else if (m_owner < 0) begin
         cand = st | m_pend;
         if (cand != 2'b00) begin
            if (cand == 2'b11) pick = 1 - m_last;
            else               pick = cand[1] ? 1 : 0;
            m_pend       = m_pend | st;
            m_pend[pick] = 1'b0;
            m_last       = pick;
            m_owner      = pick;
            m_deadline   = edge_n + dur(pick);
         end
      end else begin
         other = 1 - m_owner;
         if (st[other]) m_pend[other] = 1'b1;
         if (!en[m_owner])       m_owner = -1;
         else if (st[m_owner])   m_deadline = edge_n + dur(m_owner);
      end
      e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
      e_busy  = (m_owner >= 0);
      e_to    = (m_owner >= 0 && edge_n >= m_deadline) ? e_grant : 2'b00;
      e_pend  = m_pend;
   endtask

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("model_grant",   bus.grant,          e_grant);
         chk("model_timeOut", bus.timeOut,        e_to);
         chk("model_busy",    {1'b0, bus.busy},   {1'b0, e_busy});
         chk("model_pending", bus.pending,        e_pend);
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] st, input logic [1:0] en,
                        input logic [2:0] c0, input logic [2:0] c1);
      bus.startTimer  = st;
      bus.enableTimer = en;
      bus.timeToWait0 = c0;
      bus.timeToWait1 = c1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(2'b00, 2'b00, 3'd0, 3'd0);
      step(1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(2'b00, 2'b00, 3'd0, 3'd0);
      step(2);
      chk("rst_grant",   bus.grant,        2'b00);
      chk("rst_timeOut", bus.timeOut,      2'b00);
      chk("rst_busy",    {1'b0, bus.busy}, 2'b00);
      chk("rst_pending", bus.pending,      2'b00);
      reset = 1'b0;

      // 1: RX code 4 = 8 cycles; grant next cycle, timeOut 8 cycles after grant.
      drive(2'b01, 2'b01, 3'd4, 3'd0);
      step(1);
      chk("t1_grant", bus.grant, 2'b01);
      drive(2'b00, 2'b01, 3'd4, 3'd0);
      step(7);
      chk("t1_to_early", bus.timeOut, 2'b00);
      step(1);
      chk("t1_to", bus.timeOut, 2'b01);
      step(3);
      chk("t1_to_hold", bus.timeOut, 2'b01);
      drive(2'b00, 2'b00, 3'd4, 3'd0);
      step(1);
      chk("t1_rel_grant", bus.grant, 2'b00);
      chk("t1_rel_to",    bus.timeOut, 2'b00);
      chk("t1_rel_busy",  {1'b0, bus.busy}, 2'b00);

      // 2: simultaneous starts; RX wins, TX pending served after release; then round-robin.
      do_reset();
      drive(2'b11, 2'b11, 3'd5, 3'd5);
      step(1);
      chk("t2_grant", bus.grant, 2'b01);
      chk("t2_pend",  bus.pending, 2'b10);
      drive(2'b00, 2'b11, 3'd5, 3'd5);
      step(3);
      drive(2'b00, 2'b10, 3'd5, 3'd5);
      step(1);
      chk("t2_idle", bus.grant, 2'b00);
      step(1);
      chk("t2_tx_grant", bus.grant, 2'b10);
      chk("t2_pend_clr", bus.pending, 2'b00);
      drive(2'b00, 2'b00, 3'd5, 3'd5);
      step(1);
      drive(2'b11, 2'b11, 3'd5, 3'd5);
      step(1);
      chk("t2_rr_grant", bus.grant, 2'b01);
      drive(2'b00, 2'b11, 3'd5, 3'd5);
      step(2);

      // 3: TX owns with code 3, RX start at cycle 5 stays pending until TX releases.
      do_reset();
      drive(2'b10, 2'b10, 3'd6, 3'd3);
      step(1);
      chk("t3_grant", bus.grant, 2'b10);
      drive(2'b00, 2'b11, 3'd6, 3'd3);
      step(4);
      drive(2'b01, 2'b11, 3'd6, 3'd3);
      step(1);
      chk("t3_pend", bus.pending, 2'b01);
      drive(2'b00, 2'b11, 3'd6, 3'd3);
      step(10);
      chk("t3_to", bus.timeOut, 2'b00);
      chk("t3_hold_grant", bus.grant, 2'b10);
      drive(2'b00, 2'b01, 3'd6, 3'd3);
      step(1);
      chk("t3_rel", bus.grant, 2'b00);
      step(1);
      chk("t3_rx_grant", bus.grant, 2'b01);
      chk("t3_pend_clr", bus.pending, 2'b00);
      step(6);

      // 4: code 0 and code 7 expire the cycle after grant/restart.
      do_reset();
      drive(2'b01, 2'b01, 3'd0, 3'd0);
      step(1);
      chk("t4_c0_to0", bus.timeOut, 2'b00);
      drive(2'b00, 2'b01, 3'd0, 3'd0);
      step(1);
      chk("t4_c0_to", bus.timeOut, 2'b01);
      drive(2'b01, 2'b01, 3'd7, 3'd0);
      step(1);
      chk("t4_c7_restart", bus.timeOut, 2'b00);
      drive(2'b00, 2'b01, 3'd7, 3'd0);
      step(1);
      chk("t4_c7_to", bus.timeOut, 2'b01);
      do_reset();
      drive(2'b10, 2'b10, 3'd0, 3'd7);
      step(1);
      drive(2'b00, 2'b10, 3'd0, 3'd7);
      step(1);
      chk("t4_tx_c7_to", bus.timeOut, 2'b10);

      // 5: owner restart with code 6 in EXPIRED re-expires 4 cycles later.
      do_reset();
      drive(2'b01, 2'b01, 3'd6, 3'd0);
      step(1);
      drive(2'b00, 2'b01, 3'd6, 3'd0);
      step(4);
      chk("t5_to", bus.timeOut, 2'b01);
      drive(2'b01, 2'b01, 3'd6, 3'd0);
      step(1);
      chk("t5_restart_clr", bus.timeOut, 2'b00);
      chk("t5_restart_grant", bus.grant, 2'b01);
      drive(2'b00, 2'b01, 3'd6, 3'd0);
      step(3);
      chk("t5_to_early", bus.timeOut, 2'b00);
      step(1);
      chk("t5_to_again", bus.timeOut, 2'b01);

      // 6: reset mid-run with pending set drops everything.
      do_reset();
      drive(2'b01, 2'b11, 3'd3, 3'd3);
      step(1);
      drive(2'b10, 2'b11, 3'd3, 3'd3);
      step(1);
      chk("t6_pend", bus.pending, 2'b10);
      drive(2'b00, 2'b11, 3'd3, 3'd3);
      step(2);
      reset = 1'b1;
      step(1);
      chk("t6_grant",   bus.grant, 2'b00);
      chk("t6_pending", bus.pending, 2'b00);
      chk("t6_busy",    {1'b0, bus.busy}, 2'b00);
      reset = 1'b0;
      step(5);
      chk("t6_no_grant", bus.grant, 2'b00);

      // 7: owner release and non-owner start in the same cycle.
      do_reset();
      drive(2'b01, 2'b01, 3'd2, 3'd6);
      step(1);
      drive(2'b00, 2'b11, 3'd2, 3'd6);
      step(2);
      drive(2'b10, 2'b10, 3'd2, 3'd6);
      step(1);
      chk("t7_rel_grant", bus.grant, 2'b00);
      chk("t7_rel_pend",  bus.pending, 2'b10);
      drive(2'b00, 2'b10, 3'd2, 3'd6);
      step(1);
      chk("t7_tx_grant", bus.grant, 2'b10);
      step(4);
      chk("t7_tx_to", bus.timeOut, 2'b10);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
